// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding decode.
// Owns the PC, issues word-aligned reads under a credit limit, buffers in-order
// responses and presents a registered {insn_valid, insn_addr, insn} to decode.
// Redirects flush the buffer and discard responses still in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_req_valid/ready/addr      instruction memory read request (word address)
//   mem_rsp_valid/data            in-order read response, never back-pressured
//   redirect_valid/addr           branch/exception redirect target (word address)
//   stall                         decode cannot accept; hold outputs
//   insn_valid/insn_addr/insn     registered instruction to decode
//   perf_fetched/perf_dropped     saturating counters (only with FETCH_PERF_EN)
//
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
module fetch_stage #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned INSN_ADDR_START = 2,
   parameter int unsigned INSN_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-INSN_ADDR_START-1:0] RESET_PC = '0,
   parameter int unsigned BUF_DEPTH       = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   output logic                                  mem_req_valid,
   input  logic                                  mem_req_ready,
   output logic [ADDR_WIDTH-INSN_ADDR_START-1:0] mem_req_addr,
   input  logic                                  mem_rsp_valid,
   input  logic [INSN_WIDTH-1:0]                 mem_rsp_data,
   input  logic                                  redirect_valid,
   input  logic [ADDR_WIDTH-INSN_ADDR_START-1:0] redirect_addr,
   input  logic                                  stall,
`ifdef FETCH_PERF_EN
   output logic [31:0]                           perf_fetched,
   output logic [31:0]                           perf_dropped,
`endif
   output logic                                  insn_valid,
   output logic [ADDR_WIDTH-INSN_ADDR_START-1:0] insn_addr,
   output logic [INSN_WIDTH-1:0]                 insn
);

   localparam int unsigned AW = ADDR_WIDTH - INSN_ADDR_START;
   localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

   typedef struct packed {
      logic [AW-1:0]         addr;
      logic [INSN_WIDTH-1:0] data;
   } entry_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic [AW-1:0] tag_q [BUF_DEPTH];
   entry_t        buf_q [BUF_DEPTH];
   logic [PW-1:0] tag_wr, tag_rd, buf_wr, buf_rd;
   logic [CW-1:0] outstanding, buf_cnt, drop_cnt, drop_reload;
   logic          credit_ok, req_fire, rsp_take, drop_rsp, push_buf, pop_buf;

   // Request credit: every in-flight read must already own a buffer slot.
   assign credit_ok     = ({1'b0, outstanding} + {1'b0, buf_cnt}) < DEPTH_C;
   assign mem_req_valid = !rst && (state != BOOT) && !redirect_valid && credit_ok;
   assign mem_req_addr  = pc;
   assign req_fire      = mem_req_valid && mem_req_ready;

   // Responses are ignored during BOOT; otherwise discarded on redirect or while
   // reads issued before the last redirect are still draining.
   assign rsp_take    = mem_rsp_valid && (state != BOOT);
   assign drop_rsp    = rsp_take && (redirect_valid || (drop_cnt != '0));
   assign push_buf    = rsp_take && !drop_rsp;
   assign pop_buf     = !redirect_valid && !stall && (buf_cnt != '0);
   assign drop_reload = outstanding - CW'(rsp_take);

   // Tag queue and response buffer storage (no reset needed).
   always_ff @(posedge clk) begin
      if (req_fire) tag_q[tag_wr] <= pc;
      if (push_buf) buf_q[buf_wr] <= '{addr: tag_q[tag_rd], data: mem_rsp_data};
   end

   // Control state, pointers, counters and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         tag_wr      <= '0;
         tag_rd      <= '0;
         buf_wr      <= '0;
         buf_rd      <= '0;
         outstanding <= '0;
         buf_cnt     <= '0;
         drop_cnt    <= '0;
         insn_valid  <= 1'b0;
         insn_addr   <= '0;
         insn        <= '0;
      end else begin
         case (state)
            BOOT:    state <= RUN;
            RUN, FLUSH: begin
               if (redirect_valid)
                  state <= (drop_reload != '0) ? FLUSH : RUN;
               else if ((state == FLUSH) && drop_rsp && (drop_cnt == CW'(1)))
                  state <= RUN;
            end
            default: state <= BOOT;
         endcase

         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
         if (req_fire) tag_wr <= tag_wr + PW'(1);
         if (rsp_take) tag_rd <= tag_rd + PW'(1);

         if (redirect_valid) begin
            pc         <= redirect_addr;
            drop_cnt   <= drop_reload;
            buf_wr     <= '0;
            buf_rd     <= '0;
            buf_cnt    <= '0;
            insn_valid <= 1'b0;
         end else begin
            if (req_fire) pc <= pc + AW'(1);
            if (drop_rsp) drop_cnt <= drop_cnt - CW'(1);
            if (push_buf) buf_wr <= buf_wr + PW'(1);
            if (pop_buf)  buf_rd <= buf_rd + PW'(1);
            buf_cnt <= buf_cnt + CW'(push_buf) - CW'(pop_buf);
            // Output loads only from entries already buffered; no same-cycle bypass.
            if (!stall) begin
               insn_valid <= pop_buf;
               if (pop_buf) begin
                  insn_addr <= buf_q[buf_rd].addr;
                  insn      <= buf_q[buf_rd].data;
               end
            end
         end
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating counters: instructions handed to decode, responses discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         if (insn_valid && !stall && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
         if (drop_rsp && (perf_dropped != '1))             perf_dropped <= perf_dropped + 32'd1;
      end
   end
`else
   // Performance counters not built.
`endif

   // A response with nothing outstanding is a memory protocol error.
   rsp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
      (mem_rsp_valid && (state != BOOT)) |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage against a queue-based model.
module tb_fetch_stage;
   localparam int unsigned AW = 30;
   localparam int unsigned IW = 32;
   localparam int unsigned D  = 2;
   localparam logic [AW-1:0] RPC = 30'h100;

   logic          clk;
   logic          rst, mem_req_valid, mem_req_ready, mem_rsp_valid;
   logic [AW-1:0] mem_req_addr, redirect_addr, insn_addr;
   logic [IW-1:0] mem_rsp_data, insn;
   logic          redirect_valid, stall, insn_valid;
`ifdef FETCH_PERF_EN
   logic [31:0]   perf_fetched, perf_dropped;
`endif

   fetch_stage #(.ADDR_WIDTH(32), .INSN_ADDR_START(2), .INSN_WIDTH(IW),
                 .RESET_PC(RPC), .BUF_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .stall(stall),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched), .perf_dropped(perf_dropped),
`endif
      .insn_valid(insn_valid), .insn_addr(insn_addr), .insn(insn));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec, n_err, cyc, lat, last_due, first_req, boot_cyc;
   logic [AW-1:0] mq_addr[$];
   int            mq_due[$];
   logic [AW-1:0] got[$];

   // Reference model state
   logic [AW-1:0] m_pc, m_a;
   logic [IW-1:0] m_i;
   logic [AW-1:0] m_tags[$];
   logic [AW-1:0] m_baddr[$];
   logic [IW-1:0] m_bdata[$];
   int            m_drop;
   bit            m_boot, m_v, exp_req;
   longint        m_pf, m_pd;

   function automatic logic [IW-1:0] hash(input logic [AW-1:0] a);
      logic [31:0] w;
      w = {2'b00, a};
      return IW'((w * 32'h9E37_79B1) ^ 32'h1234_5678);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_got(input string name, input int idx, input logic [63:0] exp);
      if (idx >= got.size()) chk(name, 64'hDEAD_DEAD_DEAD_DEAD, exp);
      else                   chk(name, 64'(got[idx]), exp);
   endtask

   task automatic model_reset();
      m_pc = RPC; m_tags.delete(); m_baddr.delete(); m_bdata.delete();
      m_drop = 0; m_boot = 1; m_v = 0; m_a = '0; m_i = '0; m_pf = 0; m_pd = 0;
   endtask

   // Advance the model by one clock using this cycle's inputs.
   task automatic model_step();
      logic [AW-1:0] t;
      bit keep;
      if (rst) begin model_reset(); return; end
      if (m_v && !stall) m_pf++;
      keep = 0; t = '0;
      if (mem_rsp_valid && !m_boot) begin
         if (m_tags.size() > 0) t = m_tags.pop_front();
         if (redirect_valid || m_drop > 0) begin
            if (!redirect_valid) m_drop--;
            m_pd++;
         end else keep = 1;
      end
      if (redirect_valid) begin
         m_pc = redirect_addr; m_baddr.delete(); m_bdata.delete();
         m_drop = m_tags.size(); m_v = 0;
      end else begin
         if (exp_req && mem_req_ready) begin m_tags.push_back(m_pc); m_pc = AW'(m_pc + 1); end
         if (!stall) begin
            if (m_baddr.size() > 0) begin
               m_a = m_baddr.pop_front(); m_i = m_bdata.pop_front(); m_v = 1;
            end else m_v = 0;
         end
         if (keep) begin m_baddr.push_back(t); m_bdata.push_back(mem_rsp_data); end
      end
      m_boot = 0;
   endtask

   // One clock: check registered outputs, drive memory, check request, step model.
   task automatic run_cycle();
      int due;
      chk("insn_valid", 64'(insn_valid), 64'(m_v));
      chk("insn_addr",  64'(insn_addr),  64'(m_a));
      chk("insn",       64'(insn),       64'(m_i));
`ifdef FETCH_PERF_EN
      chk("perf_fetched", 64'(perf_fetched), 64'(m_pf));
      chk("perf_dropped", 64'(perf_dropped), 64'(m_pd));
`endif
      if (rst) begin
         mq_addr.delete(); mq_due.delete(); last_due = -1; mem_rsp_valid = 0; mem_rsp_data = '0;
      end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         mem_rsp_valid = 1; mem_rsp_data = hash(mq_addr.pop_front()); void'(mq_due.pop_front());
      end else begin
         mem_rsp_valid = 0; mem_rsp_data = $urandom;
      end
      #1;
      exp_req = !rst && !m_boot && !redirect_valid && ((m_tags.size() + m_baddr.size()) < D);
      chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_req));
      chk("mem_req_addr",  64'(mem_req_addr),  64'(m_pc));
      if (insn_valid && !stall) got.push_back(insn_addr);
      if (!rst && mem_req_valid && mem_req_ready) begin
         if (first_req < 0) first_req = cyc;
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         mq_addr.push_back(mem_req_addr); mq_due.push_back(due); last_due = due;
      end
      model_step();
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      int n;
      n_vec = 0; n_err = 0; cyc = 0; lat = 1; last_due = -1; first_req = -1;
      rst = 1; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
      redirect_valid = 0; redirect_addr = '0; stall = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("reset_insn_valid", 64'(insn_valid), 64'd0);
      chk("reset_insn_addr",  64'(insn_addr),  64'd0);
      chk("reset_insn",       64'(insn),       64'd0);
      chk("reset_req_valid",  64'(mem_req_valid), 64'd0);
      run_cycle();

      // Straight-line fetch from RESET_PC with 1-cycle memory
      rst = 0; mem_req_ready = 1; boot_cyc = cyc; got.delete();
      repeat (30) run_cycle();
      chk("first_req_after_boot", 64'(first_req - boot_cyc), 64'd1);
      chk_got("stream0", 0, 64'h100);
      chk_got("stream1", 1, 64'h101);
      chk_got("stream2", 2, 64'h102);

      // Memory not ready: buffer drains, insn_valid falls
      mem_req_ready = 0;
      repeat (5) run_cycle();
      chk("drained_invalid", 64'(insn_valid), 64'd0);
      mem_req_ready = 1;

      // Decode stall for 4 cycles
      stall = 1; repeat (4) run_cycle();
      stall = 0; repeat (10) run_cycle();

      // Redirect with two reads in flight at latency 3
      lat = 3; n = 0;
      while (m_tags.size() != D && n < 50) begin run_cycle(); n++; end
      if (n >= 50) chk("wait_two_outstanding", 64'(m_tags.size()), 64'(D));
      begin
         longint pd0;
         pd0 = m_pd;
         redirect_valid = 1; redirect_addr = 30'h40;
         run_cycle();
         redirect_valid = 0; got.delete();
         repeat (20) run_cycle();
         chk("redirect_dropped_two", 64'(m_pd - pd0), 64'd2);
         chk_got("redirect_first_addr", 0, 64'h40);
      end

      // Redirect while stalled with a valid instruction
      lat = 1; n = 0;
      while (!m_v && n < 50) begin run_cycle(); n++; end
      stall = 1; redirect_valid = 1; redirect_addr = 30'h200;
      run_cycle();
      chk("redirect_kills_valid", 64'(insn_valid), 64'd0);
      stall = 0; redirect_valid = 0;
      repeat (10) run_cycle();

      // PC wrap at the top of the word address space
      mem_req_ready = 0; repeat (8) run_cycle();
      mem_req_ready = 1; redirect_valid = 1; redirect_addr = '1;
      run_cycle();
      redirect_valid = 0; got.delete();
      repeat (12) run_cycle();
      chk_got("wrap_max", 0, 64'h3FFF_FFFF);
      chk_got("wrap_zero", 1, 64'h0);

      // Randomized traffic with occasional resets and latency changes
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) lat = int'($urandom_range(1, 4));
         rst            = ($urandom_range(0, 299) == 0);
         mem_req_ready  = ($urandom_range(0, 3) != 0);
         stall          = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_addr  = ($urandom_range(0, 7) == 0) ? '1 : AW'($urandom);
         run_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
